uart_rx_deframer: RTL
=====================

UART_RX_DEFRAMER -- requirements
Module: uart_rx_deframer

Interface
REQ-001: Parameter DATA_BITS, default 8, number of data bits per frame, legal range 5..9.
REQ-002: Parameter PARITY_EN, default 1, 1 = a parity bit follows the data bits, 0 = no parity bit.
REQ-003: Parameter PARITY_ODD, default 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.
REQ-004: Parameter STOP_BITS, default 1, number of stop bits checked, legal values 1 or 2.
REQ-005: Parameter MSB_FIRST, default 0, 0 = first data bit lands in data_out[0], 1 = first data bit lands in data_out[DATA_BITS-1].
REQ-006: clk  input  1  clock; all state changes on rising edge.
REQ-007: rst  input  1  reset, asynchronous, active-high.
REQ-008: enable  input  1  receiver enable; low aborts any frame in progress.
REQ-009: bit_strobe  input  1  one-cycle pulse at the bit-centre sample point.
REQ-010: rx_bit  input  1  sampled line value; valid only when bit_strobe=1.
REQ-011: data_out  output  DATA_BITS  received data word from the holding register.
REQ-012: out_valid  output  1  holding register contains an unconsumed frame.
REQ-013: out_ready  input  1  consumer accepts the frame when high together with out_valid.
REQ-014: parity_err  output  1  parity mismatch for the frame in the holding register.
REQ-015: frame_err  output  1  at least one stop bit sampled as 0 for the frame in the holding register.
REQ-016: overrun  output  1  sticky flag: a completed frame was dropped because the holding register was full.
REQ-017: clr_overrun  input  1  one-cycle pulse that clears overrun.
REQ-018: busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-019: The FSM SHALL have four states: IDLE, DATA, PARITY and STOP.
REQ-020: All state transitions SHALL occur only on edges where bit_strobe=1 and enable=1, except the abort path in REQ-027.
REQ-021: In IDLE, a strobe with rx_bit=0 (start bit) SHALL clear the bit counter and shift register and go to DATA; a strobe with rx_bit=1 SHALL be ignored.
REQ-022: In DATA, each strobe SHALL shift rx_bit into the shift register per MSB_FIRST; after the DATA_BITS-th strobe the FSM SHALL go to PARITY if PARITY_EN=1, otherwise to STOP.
REQ-023: In PARITY, the strobe SHALL capture the parity bit. The error is mismatch versus XOR(data) when PARITY_ODD=0, or versus ~XOR(data) when PARITY_ODD=1. The FSM then goes to STOP.
REQ-024: In STOP, each strobe with rx_bit=0 SHALL set the pending frame error.
  - All STOP_BITS stop bits are always consumed; a bad first stop bit does not end the frame early.
  - The FSM returns to IDLE on the final stop strobe.
REQ-025: On the final stop strobe edge, the frame SHALL complete. Outputs update on that same edge (latency 1 clk after the strobe cycle).
  - Holding register empty, or out_ready=1 at that edge: data, parity_err and frame_err are loaded, and out_valid=1.
  - Otherwise: the frame is discarded, the holding register is unchanged, and overrun is set.
REQ-026: out_valid SHALL clear on an edge with out_valid=1 and out_ready=1, unless a frame completes on the same edge (REQ-025).
REQ-027: enable=0 SHALL force the FSM to IDLE at the next edge and discard the partial frame; the holding register, out_valid and overrun are unaffected.
REQ-028: If clr_overrun and an overrun event coincide on the same edge, overrun SHALL end the edge set (set wins).
REQ-029: When PARITY_EN=0, parity_err SHALL be loaded as 0.

Reset
REQ-030: While rst is high, the block SHALL hold: FSM=IDLE, bit counter=0, shift register=0, data_out=0, out_valid=0, parity_err=0, frame_err=0, overrun=0, busy=0.
REQ-031: Reset asserted mid-frame SHALL discard the frame; no out_valid pulse results.
REQ-032: After rst deasserts, the first frame SHALL be recognised from the next start-bit strobe.

Verification
REQ-033: Defaults, out_ready=1, frame 0 | 1,0,1,0,0,1,0,1 (LSB first) | parity 0 | stop 1 -> data_out=0xA5, out_valid for 1 cycle, parity_err=0, frame_err=0.
REQ-034: Same frame with parity bit 1 -> data_out=0xA5, parity_err=1. With PARITY_ODD=1, parity bit 1 -> parity_err=0.
REQ-035: STOP_BITS=2, stop bits 0,1 -> frame_err=1 and completion only after the second stop strobe. Stop bits 1,1 -> frame_err=0.
REQ-036: out_ready=0, two frames 0x11 then 0x22 -> data_out stays 0x11, overrun=1. After clr_overrun -> overrun=0. With out_ready=1 at the second completion -> data_out=0x22 and overrun=0.
REQ-037: enable dropped after 3 data bits, then a full frame 0x3C -> only 0x3C is delivered. Same test with rst pulsed mid-frame -> all outputs 0, then 0x3C is delivered.
REQ-038: DATA_BITS=5, MSB_FIRST=1, PARITY_EN=0, bits 1,0,0,1,1 -> data_out=5'b10011.

Source files
------------

// File: rtl/uart_rx_deframer.sv
// UART receive deframer: turns bit-centre samples into data words with
// parity/stop checking, a single-entry holding register and a sticky overrun flag.
module uart_rx_deframer #(
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned PARITY_EN  = 1,
   parameter int unsigned PARITY_ODD = 0,
   parameter int unsigned STOP_BITS  = 1,
   parameter int unsigned MSB_FIRST  = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enable,
   input  logic                 bit_strobe,
   input  logic                 rx_bit,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 overrun,
   input  logic                 clr_overrun,
   output logic                 busy
);

   localparam int unsigned CNT_W = $clog2(DATA_BITS);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } state_t;

   state_t               state, state_n;
   logic [CNT_W-1:0]     bit_cnt, bit_cnt_n;
   logic [DATA_BITS-1:0] shift_reg, shift_reg_n;
   logic                 par_pend, par_pend_n;
   logic                 frm_pend, frm_pend_n;
   logic [DATA_BITS-1:0] data_out_n;
   logic                 out_valid_n;
   logic                 parity_err_n;
   logic                 frame_err_n;
   logic                 overrun_n;
   logic                 busy_n;
   logic                 last_stop;

   // State and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         bit_cnt    <= '0;
         shift_reg  <= '0;
         par_pend   <= 1'b0;
         frm_pend   <= 1'b0;
         data_out   <= '0;
         out_valid  <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state      <= state_n;
         bit_cnt    <= bit_cnt_n;
         shift_reg  <= shift_reg_n;
         par_pend   <= par_pend_n;
         frm_pend   <= frm_pend_n;
         data_out   <= data_out_n;
         out_valid  <= out_valid_n;
         parity_err <= parity_err_n;
         frame_err  <= frame_err_n;
         overrun    <= overrun_n;
         busy       <= busy_n;
      end
   end

   // Next-state, frame assembly and holding-register update
   always_comb begin
      state_n      = state;
      bit_cnt_n    = bit_cnt;
      shift_reg_n  = shift_reg;
      par_pend_n   = par_pend;
      frm_pend_n   = frm_pend;
      data_out_n   = data_out;
      out_valid_n  = out_valid;
      parity_err_n = parity_err;
      frame_err_n  = frame_err;
      overrun_n    = overrun & ~clr_overrun;
      last_stop    = 1'b0;

      if (!enable) begin
         state_n = IDLE;
      end else if (bit_strobe) begin
         case (state)
            IDLE: begin
               if (!rx_bit) begin
                  state_n     = DATA;
                  bit_cnt_n   = '0;
                  shift_reg_n = '0;
                  par_pend_n  = 1'b0;
                  frm_pend_n  = 1'b0;
               end
            end
            DATA: begin
               if (MSB_FIRST != 0) shift_reg_n = {shift_reg[DATA_BITS-2:0], rx_bit};
               else                shift_reg_n = {rx_bit, shift_reg[DATA_BITS-1:1]};
               if (bit_cnt == CNT_W'(DATA_BITS - 1)) begin
                  bit_cnt_n = '0;
                  state_n   = (PARITY_EN != 0) ? PARITY : STOP;
               end else begin
                  bit_cnt_n = bit_cnt + CNT_W'(1);
               end
            end
            PARITY: begin
               // Odd parity expects the inverted XOR, so fold the mode into the compare.
               par_pend_n = rx_bit ^ (^shift_reg) ^ (PARITY_ODD != 0);
               state_n    = STOP;
            end
            STOP: begin
               if (!rx_bit) frm_pend_n = 1'b1;
               if (bit_cnt == CNT_W'(STOP_BITS - 1)) begin
                  state_n   = IDLE;
                  bit_cnt_n = '0;
                  last_stop = 1'b1;
               end else begin
                  bit_cnt_n = bit_cnt + CNT_W'(1);
               end
            end
            default: state_n = IDLE;
         endcase
      end

      if (out_valid && out_ready) out_valid_n = 1'b0;

      // A completing frame overrides the consume-clear; set beats clr_overrun.
      if (last_stop) begin
         if (!out_valid || out_ready) begin
            data_out_n   = shift_reg;
            parity_err_n = (PARITY_EN != 0) && par_pend;
            frame_err_n  = frm_pend | ~rx_bit;
            out_valid_n  = 1'b1;
         end else begin
            overrun_n = 1'b1;
         end
      end

      busy_n = (state_n != IDLE);
   end

endmodule
